// File: rtl/bot_dispatch_scheduler.sv
// bot_dispatch_scheduler
//
// Hands each bot from the upstream source to one of NUM_PIPELINES parallel
// fullPipeline instances. Each cycle at most one bot is issued, to the first
// eligible pipeline found searching upward from a round-robin pointer.
//
// A pipeline is eligible when it is enabled, its reported FIFO fullness is at
// or below FULLNESS_THRESHOLD, and its cooldown counter is zero. The fullness
// report lags the real FIFO state. The cooldown keeps a pipeline out of the
// rotation for COOLDOWN cycles after each issue, which covers that lag.
//
// Ports:
//   clk                   clock
//   rst                   asynchronous reset, active-low
//   inValid / inReady     upstream handshake (inReady is combinational)
//   inBot                 128-bit bot graph
//   inBotIndex            bot index
//   inValidPermutations   per-permutation valid mask; all-zero means drop
//   fifoFullness          per-pipeline fullness, pipeline p at slice p
//   pipelineEnable        per-pipeline enable mask
//   outBot/outBotIndex/outValidPermutations  registered broadcast data
//   outIsBotValid         one-hot strobe naming the target pipeline
//   botsIssued            bots issued to a pipeline (wraps)
//   botsDropped           accepted bots with an all-zero mask (wraps)
//   idle                  no cooldown running and no strobe active

module bot_dispatch_scheduler #(
  parameter int NUM_PIPELINES      = 4,
  parameter int ADDR_WIDTH         = 9,
  parameter int FULLNESS_WIDTH     = 5,
  parameter int FULLNESS_THRESHOLD = 20,
  parameter int COOLDOWN           = 6
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     inValid,
  output logic                                     inReady,
  input  logic [127:0]                             inBot,
  input  logic [ADDR_WIDTH-1:0]                    inBotIndex,
  input  logic [5:0]                               inValidPermutations,
  input  logic [NUM_PIPELINES*FULLNESS_WIDTH-1:0]  fifoFullness,
  input  logic [NUM_PIPELINES-1:0]                 pipelineEnable,
  output logic [127:0]                             outBot,
  output logic [ADDR_WIDTH-1:0]                    outBotIndex,
  output logic [5:0]                               outValidPermutations,
  output logic [NUM_PIPELINES-1:0]                 outIsBotValid,
  output logic [31:0]                              botsIssued,
  output logic [31:0]                              botsDropped,
  output logic                                     idle
);

  localparam int PTR_W = $clog2(NUM_PIPELINES);
  // A cooldown of 0 still needs a 1-bit counter so the array stays legal.
  localparam int CD_W  = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

  logic [PTR_W-1:0]         rrPtr;
  logic [CD_W-1:0]          cooldown [NUM_PIPELINES];
  logic [NUM_PIPELINES-1:0] eligible;
  logic [NUM_PIPELINES-1:0] cooldownZeroNext;

  logic                     accept;
  logic                     issue;
  logic                     drop;
  logic                     found;
  logic [PTR_W-1:0]         target;
  logic [PTR_W-1:0]         rrPtrNext;
  int                       idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PIPELINES; gi++) begin : genPipe
      logic [CD_W-1:0] cdNext;

      // Widen the fullness slice so a threshold above the slice range is
      // still compared correctly.
      assign eligible[gi] = pipelineEnable[gi]
                          & ({{(32-FULLNESS_WIDTH){1'b0}}, fifoFullness[gi*FULLNESS_WIDTH +: FULLNESS_WIDTH]}
                             <= 32'(FULLNESS_THRESHOLD))
                          & (cooldown[gi] == '0);

      // Loading on issue wins over the free-running decrement.
      always_comb begin
        cdNext = cooldown[gi];
        if (issue && (target == PTR_W'(gi))) begin
          cdNext = CD_LOAD;
        end else if (cooldown[gi] != '0) begin
          cdNext = cooldown[gi] - CD_W'(1);
        end
      end

      assign cooldownZeroNext[gi] = (cdNext == '0);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cooldown[gi] <= '0;
        end else begin
          cooldown[gi] <= cdNext;
        end
      end
    end
  endgenerate

  assign inReady = |eligible;
  assign accept  = inValid & inReady;
  assign issue   = accept & (|inValidPermutations);
  assign drop    = accept & ~(|inValidPermutations);

  // Round-robin search: first eligible pipeline at or above rrPtr, wrapping.
  always_comb begin
    found  = 1'b0;
    target = '0;
    idx    = 0;
    for (int i = 0; i < NUM_PIPELINES; i++) begin
      idx = int'(rrPtr) + i;
      if (idx >= NUM_PIPELINES) begin
        idx = idx - NUM_PIPELINES;
      end
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        target = PTR_W'(idx);
      end
    end
  end

  assign rrPtrNext = (target == PTR_W'(NUM_PIPELINES - 1)) ? '0 : target + PTR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rrPtr                <= '0;
      outBot               <= '0;
      outBotIndex          <= '0;
      outValidPermutations <= '0;
      outIsBotValid        <= '0;
      botsIssued           <= '0;
      botsDropped          <= '0;
      idle                 <= 1'b0;
    end else begin
      outIsBotValid <= issue ? (NUM_PIPELINES'(1) << target) : '0;
      if (issue) begin
        outBot               <= inBot;
        outBotIndex          <= inBotIndex;
        outValidPermutations <= inValidPermutations;
        rrPtr                <= rrPtrNext;
        botsIssued           <= botsIssued + 32'd1;
      end
      if (drop) begin
        botsDropped <= botsDropped + 32'd1;
      end
      // Computed from next-state values so idle describes the same cycle
      // as the cooldown and strobe registers it summarises.
      idle <= (&cooldownZeroNext) & ~issue;
    end
  end

endmodule

// File: doc/bot_dispatch_scheduler.md
Name: bot_dispatch_scheduler

Overview:
Distributes the incoming bot stream (bot, index, 6-bit permutation mask) across NUM_PIPELINES parallel fullPipeline instances. Each cycle at most one bot goes to one pipeline, chosen round-robin among pipelines whose FIFO fullness is under threshold. Each pipeline reports fullness with a delay, so a per-pipeline cooldown counter keeps the scheduler from overfilling that pipeline's FIFO. Sits between the bot source and the fullPipeline array.

Parameters:
NUM_PIPELINES, 4, number of downstream pipelines (2..16)
ADDR_WIDTH, 9, width of bot index
FULLNESS_WIDTH, 5, width of each pipeline's fifoFullness
FULLNESS_THRESHOLD, 20, pipeline eligible only if fifoFullness <= this
COOLDOWN, 6, cycles a pipeline is ineligible after an issue; 0 disables cooldown

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
inValid  in  1  upstream bot valid
inReady  out  1  scheduler accepts the bot this cycle
inBot  in  128  bot graph
inBotIndex  in  ADDR_WIDTH  bot index
inValidPermutations  in  6  per-permutation valid mask
fifoFullness  in  NUM_PIPELINES*FULLNESS_WIDTH  per-pipeline fullness, pipeline p at slice p
pipelineEnable  in  NUM_PIPELINES  per-pipeline enable mask
outBot  out  128  bot broadcast to all pipelines
outBotIndex  out  ADDR_WIDTH  index broadcast
outValidPermutations  out  6  mask broadcast
outIsBotValid  out  NUM_PIPELINES  one-hot strobe selecting the target pipeline
botsIssued  out  32  count of issued bots
botsDropped  out  32  count of accepted bots with an all-zero mask
idle  out  1  all cooldowns zero and no strobe active

Behaviour:
- Reset (rst=0, async): all outputs 0, all cooldown counters 0, rrPtr 0, counters 0. A strobe in flight at reset is lost and is not counted.
- eligible[p] = pipelineEnable[p] & (fifoFullness[p] <= FULLNESS_THRESHOLD) & (cooldown[p]==0).
- inReady = |eligible. It is combinational and independent of inValid.
- Accept = inValid & inReady.
- Accept with inValidPermutations==0:
  - no issue; botsDropped increments.
  - rrPtr and cooldowns are unchanged; outIsBotValid is 0 next cycle.
- Accept with nonzero mask (issue):
  - target = first eligible pipeline searching upward from rrPtr, wrapping modulo NUM_PIPELINES.
  - Next cycle: outIsBotValid = one-hot(target); outBot/outBotIndex/outValidPermutations = registered inputs.
  - Latency is exactly 1 cycle from accept to strobe.
- On issue:
  - cooldown[target] loads COOLDOWN.
  - rrPtr <= target+1 (wraps to 0 after NUM_PIPELINES-1).
  - botsIssued increments.
- Every cycle, each nonzero cooldown not being loaded decrements by 1. A load in the same cycle wins over the decrement.
- No accept: outIsBotValid = 0. Data outputs hold their last value.
- With COOLDOWN=0, the same pipeline may be issued on consecutive cycles.
- Counters wrap modulo 2^32.
- idle = (all cooldown==0) & (outIsBotValid==0), registered.
- Boundaries:
  - All pipelines full or disabled: inReady=0 and state frozen except cooldown decrement.
  - pipelineEnable deasserted mid-cooldown: the cooldown still runs down; the pipeline is not selected while disabled.
  - fifoFullness exactly equal to the threshold: eligible.
  - rrPtr pointing at an ineligible pipeline: the search skips it.
- Fairness guarantee: with all pipelines continuously eligible, issue order is 0,1,...,N-1,0,...

Test Plan:
- Reset, all fullness 0, enable 4'b1111, COOLDOWN=0, 8 back-to-back nonzero-mask bots -> strobes 0001,0010,0100,1000,0001,...; botsIssued=8; each strobe 1 cycle after accept.
- COOLDOWN=6, only pipeline 0 enabled, bots continuous -> issue on cycles t, t+7, t+14; inReady low for the 6 cycles in between.
- fifoFullness[1]=21, [2]=20, others 0, rrPtr=1 -> next issue goes to pipeline 2; pipeline 1 is skipped; botsIssued+1.
- Bot with inValidPermutations=6'b0 between valid bots -> no strobe, botsDropped=1, rrPtr unchanged (next issue is the same pipeline it would otherwise have been).
- All pipelines fullness 31 -> inReady=0 and no strobes. Drop pipeline 3 to 5 -> inReady=1 and the next bot goes to 1000.
- Assert rst low mid-stream while a strobe is pending -> outIsBotValid=0, counters=0, idle=0 immediately (asynchronously). After release, the first issue targets pipeline 0.
